// File: rtl/slc3_pkg.sv
// Shared encodings for the SLC-3 control unit: opcodes, datapath mux
// selects, ALU operations and the control state machine states.
package slc3_pkg;

  // Opcodes of the SLC-3 subset, as found in IR[15:12]
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  // PC input select
  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  // Second address-adder operand select
  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  // ALU function select
  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // Control states; names follow the classic LC-3 state numbering, with
  // _1/_2/_3 suffixes for the stretched SRAM access windows
  typedef enum logic [4:0] {
    HALTED,
    S_18, S_33_1, S_33_2, S_33_3, S_35, S_32,
    S_01, S_05, S_09,
    S_00, S_22,
    S_12,
    S_04, S_21, S_20,
    S_06, S_25_1, S_25_2, S_25_3, S_27,
    S_07, S_23, S_16_1, S_16_2, S_16_3,
    PAUSE_IR1, PAUSE_IR2
  } state_t;

endpackage

// File: rtl/slc3_isdu.sv
// Instruction sequence decoder for the SLC-3: a Moore machine that walks the
// datapath through fetch, decode and execute, and handles the Run/Continue
// button handshakes. Every control output is a decode of the current state.
module slc3_isdu
  import slc3_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state;
  state_t next_state;

  // State register; reset parks the machine in HALTED at once, which also
  // drops any SRAM strobe in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= HALTED;
    else        state <= next_state;
  end

  // Next-state selection and control-word decode of the current state
  always_comb begin
    next_state = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_CE     = 1'b0;
    Mem_UB     = 1'b0;
    Mem_LB     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    case (state)
      HALTED: begin
        if (!Run) next_state = S_18;
      end

      S_18: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        LD_PC      = 1'b1;
        PCMUX      = PCMUX_INC;
        next_state = S_33_1;
      end
      S_33_1: begin
        Mem_OE     = 1'b0;
        next_state = S_33_2;
      end
      S_33_2: begin
        Mem_OE     = 1'b0;
        next_state = S_33_3;
      end
      S_33_3: begin
        Mem_OE     = 1'b0;
        LD_MDR     = 1'b1;
        next_state = S_35;
      end
      S_35: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        next_state = S_32;
      end
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:  next_state = S_01;
          OP_AND:  next_state = S_05;
          OP_NOT:  next_state = S_09;
          OP_BR:   next_state = S_00;
          OP_JMP:  next_state = S_12;
          OP_JSR:  next_state = S_04;
          OP_LDR:  next_state = S_06;
          OP_STR:  next_state = S_07;
          OP_PSE:  next_state = PAUSE_IR1;
          default: next_state = S_18;
        endcase
      end

      S_01, S_05, S_09: begin
        SR1MUX     = 1'b1;
        SR2MUX     = IR_5;
        ALUK       = (state == S_01) ? ALUK_ADD :
                     (state == S_05) ? ALUK_AND : ALUK_NOT;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = S_18;
      end

      S_00: begin
        next_state = BEN ? S_22 : S_18;
      end
      S_22: begin
        ADDR2MUX   = ADDR2_OFF9;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = S_18;
      end

      S_12: begin
        SR1MUX     = 1'b1;
        ALUK       = ALUK_PASSA;
        GateALU    = 1'b1;
        PCMUX      = PCMUX_BUS;
        LD_PC      = 1'b1;
        next_state = S_18;
      end

      S_04: begin
        GatePC     = 1'b1;
        DRMUX      = 1'b1;
        LD_REG     = 1'b1;
        next_state = IR_11 ? S_21 : S_20;
      end
      S_21: begin
        ADDR2MUX   = ADDR2_OFF11;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = S_18;
      end
      S_20: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_ZERO;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = S_18;
      end

      S_06, S_07: begin
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
        SR1MUX     = 1'b1;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        next_state = (state == S_06) ? S_25_1 : S_23;
      end
      S_25_1: begin
        Mem_OE     = 1'b0;
        next_state = S_25_2;
      end
      S_25_2: begin
        Mem_OE     = 1'b0;
        next_state = S_25_3;
      end
      S_25_3: begin
        Mem_OE     = 1'b0;
        LD_MDR     = 1'b1;
        next_state = S_27;
      end
      S_27: begin
        GateMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = S_18;
      end

      S_23: begin
        ALUK       = ALUK_PASSA;
        GateALU    = 1'b1;
        LD_MDR     = 1'b1;
        next_state = S_16_1;
      end
      S_16_1: begin
        Mem_WE     = 1'b0;
        next_state = S_16_2;
      end
      S_16_2: begin
        Mem_WE     = 1'b0;
        next_state = S_16_3;
      end
      S_16_3: begin
        next_state = S_18;
      end

      PAUSE_IR1: begin
        LD_LED = 1'b1;
        if (!Continue) next_state = PAUSE_IR2;
      end
      PAUSE_IR2: begin
        if (Continue) next_state = S_18;
      end

      default: next_state = HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu.sv
// Self-checking bench for slc3_isdu: a step-counting instruction model
// predicts the control word on every cycle, and directed instructions pin
// cycle counts and key control bits with hand-derived literals.
module tb_slc3_isdu;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  logic [26:0] dutOut;

  localparam int B_LDMAR   = 26;
  localparam int B_LDMDR   = 25;
  localparam int B_LDIR    = 24;
  localparam int B_LDBEN   = 23;
  localparam int B_LDCC    = 22;
  localparam int B_LDREG   = 21;
  localparam int B_LDPC    = 20;
  localparam int B_LDLED   = 19;
  localparam int B_GPC     = 18;
  localparam int B_GMDR    = 17;
  localparam int B_GALU    = 16;
  localparam int B_GMARMUX = 15;
  localparam int B_PCMUX   = 13;
  localparam int B_DRMUX   = 12;
  localparam int B_SR1     = 11;
  localparam int B_SR2     = 10;
  localparam int B_ADDR1   = 9;
  localparam int B_ADDR2   = 7;
  localparam int B_ALUK    = 5;
  localparam int B_OE      = 1;
  localparam int B_WE      = 0;
  localparam logic [26:0] IDLE_OUT = 27'd3;

  int checkCount = 0;
  int passCount  = 0;

  int mMode = 0;
  int mStep = 0;

  logic [26:0] trace [64];
  int          traceLen = 0;
  logic [26:0] cyc [1:8];

  slc3_isdu dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  assign dutOut = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                   GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                   DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                   Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

  // 50 MHz clock
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Total cycles of an instruction including its 6-cycle fetch
  function automatic int instrLength(input logic [3:0] op, input logic ben);
    case (op)
      4'b0001, 4'b0101, 4'b1001, 4'b1100: return 7;
      4'b0000: return ben ? 8 : 7;
      4'b0100: return 8;
      4'b0110, 4'b0111: return 11;
      4'b1101: return 99;
      default: return 6;
    endcase
  endfunction

  // Control word expected at a given cycle of an instruction
  function automatic logic [26:0] expectOut(input int mode, input int step, input logic [3:0] op,
                                            input logic ir5, input logic ir11);
    logic [26:0] e;
    int k;
    e = IDLE_OUT;
    k = step - 6;
    if (mode == 1) begin
      case (step)
        0: begin e[B_LDMAR] = 1; e[B_GPC] = 1; e[B_LDPC] = 1; end
        1, 2: e[B_OE] = 0;
        3: begin e[B_OE] = 0; e[B_LDMDR] = 1; end
        4: begin e[B_GMDR] = 1; e[B_LDIR] = 1; end
        5: e[B_LDBEN] = 1;
        default: begin
          case (op)
            4'b0001, 4'b0101, 4'b1001: if (k == 0) begin
              e[B_SR1] = 1; e[B_SR2] = ir5;
              e[B_ALUK +: 2] = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
              e[B_GALU] = 1; e[B_LDREG] = 1; e[B_LDCC] = 1;
            end
            4'b0000: if (k == 1) begin
              e[B_ADDR2 +: 2] = 2'd2; e[B_PCMUX +: 2] = 2'd2; e[B_LDPC] = 1;
            end
            4'b1100: if (k == 0) begin
              e[B_SR1] = 1; e[B_ALUK +: 2] = 2'd3; e[B_GALU] = 1;
              e[B_PCMUX +: 2] = 2'd1; e[B_LDPC] = 1;
            end
            4'b0100: begin
              if (k == 0) begin e[B_GPC] = 1; e[B_DRMUX] = 1; e[B_LDREG] = 1; end
              if (k == 1) begin
                e[B_PCMUX +: 2] = 2'd2; e[B_LDPC] = 1;
                if (ir11) e[B_ADDR2 +: 2] = 2'd3;
                else begin e[B_SR1] = 1; e[B_ADDR1] = 1; end
              end
            end
            4'b0110, 4'b0111: begin
              if (k == 0) begin
                e[B_ADDR1] = 1; e[B_ADDR2 +: 2] = 2'd1; e[B_SR1] = 1;
                e[B_GMARMUX] = 1; e[B_LDMAR] = 1;
              end else if (op == 4'b0110) begin
                if (k == 1 || k == 2) e[B_OE] = 0;
                if (k == 3) begin e[B_OE] = 0; e[B_LDMDR] = 1; end
                if (k == 4) begin e[B_GMDR] = 1; e[B_LDREG] = 1; e[B_LDCC] = 1; end
              end else begin
                if (k == 1) begin e[B_ALUK +: 2] = 2'd3; e[B_GALU] = 1; e[B_LDMDR] = 1; end
                if (k == 2 || k == 3) e[B_WE] = 0;
              end
            end
            4'b1101: if (k == 0) e[B_LDLED] = 1;
            default: e = IDLE_OUT;
          endcase
        end
      endcase
    end
    return e;
  endfunction

  // Reference model: cycle position inside the current instruction
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mMode <= 0;
      mStep <= 0;
    end else if (mMode == 0) begin
      if (!Run) begin mMode <= 1; mStep <= 0; end
    end else if (Opcode == 4'b1101 && mStep == 6) begin
      if (!Continue) mStep <= 7;
    end else if (Opcode == 4'b1101 && mStep == 7) begin
      if (Continue) mStep <= 0;
    end else if (mStep + 1 >= instrLength(Opcode, BEN)) begin
      mStep <= 0;
    end else begin
      mStep <= mStep + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s at %0t: actual=%0h required=%0h (model step %0d)",
                  name, $time, actual, expected, mStep);
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s at %0t: actual=bound expired required=progress", name, $time);
  endtask

  // Every cycle: DUT control word against the model
  always @(negedge Clk) begin
    checkOutput("cycle", int'(dutOut), int'(expectOut(mMode, mStep, Opcode, IR_5, IR_11)));
  end

  // Per-instruction trace of DUT outputs, restarted at each fetch S18 cycle
  always @(negedge Clk) begin
    if (GatePC && LD_MAR) begin
      trace[0] <= dutOut;
      traceLen <= 1;
    end else if (traceLen < 64) begin
      trace[traceLen[5:0]] <= dutOut;
      traceLen <= traceLen + 1;
    end
  end

  function automatic int countBit(input int b, input int val, input int from, input int upto);
    int n;
    n = 0;
    for (int i = from; i < upto; i++) if (trace[i][b] == val[0]) n++;
    return n;
  endfunction

  // Runs one instruction from its S18 cycle to the next instruction's S18
  task automatic applyStimulus(input logic [3:0] op, input logic ir5, input logic ir11,
                               input logic ben, input int pressDelay, input int holdLen);
    int b;
    b = 0;
    while (!(mMode == 1 && mStep == 0) && b < 40) begin @(posedge Clk); #2; b++; end
    if (b >= 40) reportTimeout("startWait");
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    Run = 1'($urandom_range(0, 1));
    if (op == 4'b1101) begin
      Continue = 1'b1;
      b = 0;
      while (mStep != 6 && b < 20) begin @(posedge Clk); #2; b++; end
      repeat (pressDelay) begin @(posedge Clk); #2; end
      Continue = 1'b0;
      repeat (holdLen) begin @(posedge Clk); #2; end
      Continue = 1'b1;
    end else begin
      Continue = 1'($urandom_range(0, 1));
    end
    b = 0;
    do begin @(posedge Clk); #2; b++; end while (mStep != 0 && b < 40);
    if (mStep != 0) reportTimeout("endWait");
  endtask

  initial begin
    int b;
    Reset = 1'b1; Run = 1'b1; Continue = 1'b1;
    Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("resetDefaults", int'(dutOut), int'(IDLE_OUT));
    Continue = 1'b0;
    @(posedge Clk); #2 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("haltedIgnoresContinue", int'(dutOut), int'(IDLE_OUT));

    // First fetch plus ADD immediate, sampled cycle by cycle
    @(posedge Clk); #2;
    Continue = 1'b1; Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b0;
    @(posedge Clk); #2 Run = 1'b1;
    for (int c = 1; c <= 8; c++) begin @(negedge Clk); cyc[c] = dutOut; end
    checkOutput("fetchS18", int'({cyc[1][B_LDMAR], cyc[1][B_GPC], cyc[1][B_LDPC], cyc[1][B_PCMUX +: 2]}), 5'b11100);
    b = 0;
    for (int c = 1; c <= 6; c++) if (!cyc[c][B_OE]) b++;
    checkOutput("fetchOeLowCycles", b, 3);
    b = 0;
    for (int c = 8; c >= 1; c--) if (cyc[c][B_LDIR]) b = c;
    checkOutput("fetchLdIrCycle", b, 5);
    checkOutput("addImmExec", int'({cyc[7][B_SR1], cyc[7][B_SR2], cyc[7][B_ALUK +: 2],
                                     cyc[7][B_GALU], cyc[7][B_LDREG], cyc[7][B_LDCC]}), 7'b1100111);
    checkOutput("addBackToFetch", int'({cyc[8][B_GPC], cyc[8][B_LDMAR]}), 2'b11);
    @(posedge Clk); #2;

    // Directed instructions with hand-derived cycle counts
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("brNotTakenLen", traceLen, 7);
    checkOutput("brNotTakenNoLdPc", int'(trace[6][B_LDPC]), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 0, 1);
    checkOutput("brTakenLen", traceLen, 8);
    checkOutput("brTakenS22", int'({trace[7][B_PCMUX +: 2], trace[7][B_ADDR2 +: 2], trace[7][B_LDPC]}), 5'b10101);
    applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 0, 1);
    checkOutput("jsrLen", traceLen, 8);
    checkOutput("jsrLinkS04", int'({trace[6][B_GPC], trace[6][B_DRMUX], trace[6][B_LDREG]}), 3'b111);
    checkOutput("jsrOff11", int'(trace[7][B_ADDR2 +: 2]), 3);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("jsrrS20", int'({trace[7][B_SR1], trace[7][B_ADDR1], trace[7][B_ADDR2 +: 2]}), 4'b1100);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("ldrLen", traceLen, 11);
    checkOutput("ldrOeLowCycles", countBit(B_OE, 0, 6, 11), 3);
    checkOutput("ldrMdrInThirdReadCycle", int'(trace[9][B_LDMDR]), 1);
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("strLen", traceLen, 11);
    checkOutput("strLdMdr", int'(trace[7][B_LDMDR]), 1);
    checkOutput("strWeLowCycles", countBit(B_WE, 0, 0, 11), 2);
    checkOutput("strWeWindow", int'({trace[8][B_WE], trace[9][B_WE], trace[10][B_WE]}), 3'b001);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("nopLen", traceLen, 6);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0, 5, 1);
    checkOutput("pauseLen", traceLen, 13);
    checkOutput("pauseLedHeld", countBit(B_LDLED, 1, 0, 13), 6);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0, 0, 20);
    checkOutput("pauseHeldContinueLen", traceLen, 27);
    checkOutput("pauseHeldIdle", int'(trace[26]), int'(IDLE_OUT));

    // Reset during the first SRAM write cycle
    Opcode = 4'b0111; Continue = 1'b1;
    b = 0;
    do begin @(negedge Clk); b++; end while (mStep != 8 && b < 20);
    checkOutput("strWeLowBeforeReset", int'(Mem_WE), 0);
    #1 Reset = 1'b0;
    #1 checkOutput("resetWeAsync", int'({Mem_WE, Mem_OE, GatePC}), 3'b110);
    @(posedge Clk); #2 Reset = 1'b1; Run = 1'b0;
    @(posedge Clk); #2 Run = 1'b1;

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    repeat (2) @(posedge Clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/slc3_isdu.md
# slc3_isdu

Instruction Sequence Decoder Unit for the SLC-3 CPU: a Moore state machine that sequences the datapath through fetch, decode and execute of the SLC-3 instruction subset. It sits in `slc3` beside datapath instance `d0`. It drives every register load enable, bus gate, mux select and SRAM strobe from the current state, the IR opcode fields and BEN. It also handles the Run/Continue handshakes from the board buttons.

## Interface

- No parameters. Opcode, mux-select and state encodings live in the shared package.
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low; clears state to HALTED
- Run  in  1  active-low, pre-synchronized; starts execution from HALTED
- Continue  in  1  active-low, pre-synchronized; releases PAUSE states
- Opcode  in  4  IR[15:12]
- IR_5  in  1  ADD/AND immediate select
- IR_11  in  1  JSR vs JSRR select
- BEN  in  1  branch enable from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per state
- PCMUX  out  2  00 PC+1, 01 bus, 10 adder
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  selects
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low

## Operation

- Default in every state: all LD_*/Gate* = 0, all selects = 0, Mem_CE = Mem_UB = Mem_LB = 0, Mem_OE = Mem_WE = 1.
- HALTED: no outputs asserted. Go to S18 when Run = 0.
- Fetch:
  - S18: GatePC, LD_MAR, LD_PC, PCMUX = 00.
  - S33_1, S33_2: Mem_OE = 0.
  - S33_3: Mem_OE = 0, LD_MDR.
  - S35: GateMDR, LD_IR.
  - S32: LD_BEN. Dispatch on Opcode.
- Dispatch from S32:
  - 0001 → S01 (ADD), 0101 → S05 (AND), 1001 → S09 (NOT).
  - 0000 → S00 (BR), 1100 → S12 (JMP), 0100 → S04 (JSR).
  - 0110 → S06 (LDR), 0111 → S07 (STR), 1101 → PAUSE_IR1.
  - Any other opcode → S18, treated as NOP.
- ALU ops: SR1MUX = 1, SR2MUX = IR_5, ALUK = 00 / 01 / 10, GateALU, LD_REG, LD_CC → S18.
- BR: S00 → S22 if BEN = 1, else → S18. S22: ADDR2MUX = 10, PCMUX = 10, LD_PC → S18.
- JMP: S12: SR1MUX = 1, ALUK = 11, GateALU, PCMUX = 01, LD_PC → S18.
- JSR:
  - S04: GatePC, DRMUX = 1, LD_REG → S21 if IR_11 = 1, else → S20.
  - S21: ADDR2MUX = 11, PCMUX = 10, LD_PC → S18.
  - S20: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00, PCMUX = 10, LD_PC → S18.
- LDR:
  - S06: ADDR1MUX = 1, ADDR2MUX = 01, SR1MUX = 1, GateMARMUX, LD_MAR.
  - S25_1, S25_2: Mem_OE = 0.
  - S25_3: Mem_OE = 0, LD_MDR.
  - S27: GateMDR, LD_REG, LD_CC → S18.
- STR:
  - S07: address as in S06, then → S23.
  - S23: ALUK = 11, GateALU, LD_MDR. The SR field selects the store source.
  - S16_1, S16_2: Mem_WE = 0.
  - S16_3: Mem_WE deasserted → S18.
- PAUSE:
  - PAUSE_IR1: LD_LED. Stay while Continue = 1; → PAUSE_IR2 on Continue = 0.
  - PAUSE_IR2: stay while Continue = 0; → S18 on Continue = 1.
  - One instruction retires per full press-and-release.

## Timing

- State register updates on the rising edge of Clk. All outputs are combinational decodes of the current state, so they are glitch-free relative to the next edge.
- Reset low forces HALTED immediately, with all outputs at their defaults. This applies even mid-SRAM-write: Mem_WE returns to 1 asynchronously.
- Fetch latency is 6 cycles, S18 through S32. Instruction cycle counts including fetch:
  - ALU ops and JMP: 7.
  - BR not taken: 7. BR taken: 8.
  - JSR: 8.
  - LDR: 11.
  - STR: 11.
- The SRAM read window is 3 cycles and MDR loads in the 3rd.
- The SRAM write asserts Mem_WE for exactly 2 cycles, with address and data stable one cycle before.
- Run has no effect outside HALTED. Continue has no effect outside the PAUSE states.

## Structure

- Package `slc3_pkg`:
  - opcode localparams
  - `state_t` enum
  - PCMUX, ADDR2MUX and ALUK encodings
- Single module, two always blocks: `always_ff` for state, `always_comb` for next state and outputs.
- No sub-module.

## Test plan

- Reset = 0 with Run = 1 → state HALTED; all LD_* = 0; Mem_OE = Mem_WE = 1.
- Release Reset, pulse Run = 0 → next edge S18 with GatePC = LD_MAR = LD_PC = 1. Mem_OE = 0 for exactly 3 cycles. LD_IR is high in cycle 5.
- Opcode = 0001 with IR_5 = 1 → S01 asserts SR2MUX = 1, ALUK = 00, LD_REG = LD_CC = 1, then S18.
- Opcode = 0000 with BEN = 0 → S00 then S18 with no LD_PC. With BEN = 1 → S22 with PCMUX = 10.
- Opcode = 0111 → Mem_WE = 0 in exactly 2 consecutive cycles after LD_MDR; Reset = 0 during S16_1 → Mem_WE = 1 immediately.
- Opcode = 1101 → LD_LED held. Continue = 0 → PAUSE_IR2; Continue = 1 → S18. A held Continue = 0 does not pass a second PAUSE.
